// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring sequential divider, one quotient bit per clock
// Optional signed support compiled in with DIV_SIGNED_EN.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] rem, quo, dsor;
  logic [CW-1:0]    cnt;
  logic             dz;
  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;

  assign accept = start && (state == IDLE || state == DONE);

  // quo starts as the dividend magnitude and fills with quotient bits from the LSB
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dsor};
  assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign a_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign q_fix = neg_q ? -quo_step : quo_step;
  assign r_fix = neg_r ? -rem_step : rem_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= signed_op && dividend[WIDTH-1];
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = quo_step;
  assign r_fix = rem_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_next = (divisor == '0) ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign div_by_zero = done && dz;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      quo       <= '0;
      dsor      <= '0;
      cnt       <= '0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      if (divisor == '0) begin
        dz        <= 1'b1;
        quotient  <= '1;
        remainder <= dividend;
      end else begin
        dz   <= 1'b0;
        rem  <= '0;
        quo  <= a_mag;
        dsor <= b_mag;
        cnt  <= CW'(WIDTH);
      end
    end else if (state == RUN) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;

  localparam int WIDTH = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             signed_op = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic [WIDTH-1:0] quotient, remainder;
  logic             busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] last_q = '0;
  logic [WIDTH-1:0] last_r = '0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, C-style truncating division
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                output logic [31:0] q, output logic [31:0] r);
    longint x, y;
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      if (SEN && s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'b0, a});
        y = longint'({32'b0, b});
      end
      q = 32'(x / y);
      r = 32'(x % y);
    end
  endfunction

  // Called at a negedge; returns at the negedge inside the DONE cycle
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int inject_at, input string tag);
    logic [31:0] eq, er;
    int lat, nb;
    model(a, b, s, eq, er);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
    if (b != 0) begin
      check({tag, "_hold_q"}, quotient, last_q);
      check({tag, "_hold_r"}, remainder, last_r);
    end
    lat = 0;
    nb = 0;
    while (!done && lat < 200) begin
      if (busy) nb++;
      start = (lat == inject_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, (b == 0) ? 0 : WIDTH);
    check({tag, "_busy_cycles"}, nb, (b == 0) ? 0 : WIDTH);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, (b == 0));
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    bit seen;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, -1, "u100_7");
    check("u100_7_q_const", quotient, 14);
    check("u100_7_r_const", remainder, 2);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("dz_pulse", div_by_zero, 0);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, "s_m7_2");
    @(negedge clk);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, -1, "u_m7_2");
    check("u_m7_2_q_const", quotient, 32'h7FFF_FFFC);
    check("u_m7_2_r_const", remainder, 1);
    @(negedge clk);
    run_op(32'd5, 32'd0, 1'b0, -1, "div0");
    check("div0_q_const", quotient, 32'hFFFF_FFFF);
    check("div0_r_const", remainder, 5);
    @(negedge clk);
    check("div0_dz_pulse", div_by_zero, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "ovf");
    @(negedge clk);

    // start mid-RUN is ignored; start in DONE is accepted back-to-back
    run_op(32'd1000, 32'd7, 1'b0, 10, "ignore");
    run_op(32'd9, 32'd3, 1'b0, -1, "b2b");
    check("b2b_q_const", quotient, 3);
    check("b2b_r_const", remainder, 0);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(a, b, 1'($urandom), -1, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // reset mid-RUN aborts with no done
    dividend = 32'd1000; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
